vc_pop_arbiter: RTL and testbench
=================================

VC_POP_ARBITER -- requirements
Module: vc_pop_arbiter

Interface
REQ-001 Parameter: DATA_SIZE, 6, width of every data word.
REQ-002 Parameter: VC0_BURST, 3, maximum consecutive vc0 grants while vc1 is waiting.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset_L  input  1  asynchronous, active-low reset.
REQ-005 Port: fifo_empty_vc0  input  1  empty flag of VC0 FIFO.
REQ-006 Port: fifo_empty_vc1  input  1  empty flag of VC1 FIFO.
REQ-007 Port: data_vc0  input  DATA_SIZE  VC0 FIFO pop data; valid the cycle after the pop edge.
REQ-008 Port: data_vc1  input  DATA_SIZE  VC1 FIFO pop data; same timing as data_vc0.
REQ-009 Port: pause_d0  input  1  destination-0 almost-full; blocks new pops.
REQ-010 Port: pause_d1  input  1  destination-1 almost-full; blocks new pops.
REQ-011 Port: pop_vc0  output  1  registered pop strobe to VC0 FIFO.
REQ-012 Port: pop_vc1  output  1  registered pop strobe to VC1 FIFO.
REQ-013 Port: push_d0  output  1  registered push strobe to destination 0.
REQ-014 Port: push_d1  output  1  registered push strobe to destination 1.
REQ-015 Port: data_d0  output  DATA_SIZE  word for destination 0; holds its last value when push_d0 is low.
REQ-016 Port: data_d1  output  DATA_SIZE  word for destination 1; holds its last value when push_d1 is low.
REQ-017 Port: idle  output  1  high when state is IDLE.
REQ-018 Port: words_fwd  output  8  count of words forwarded; wraps 255->0.

Function
REQ-019 The FSM SHALL have states IDLE, POP, WAIT and PUSH, and all outputs SHALL be registered.
REQ-020 In IDLE, a grant SHALL occur only when pause_d0=0, pause_d1=0 and at least one empty flag is 0; on the next edge the block SHALL assert the granted pop_vcX and enter POP.
REQ-021 Arbitration: vc0 SHALL have priority; vc1 SHALL be granted instead when vc1 is non-empty and the vc0 streak counter equals VC0_BURST.
REQ-022 vc0 streak counter: increments on each vc0 grant while vc1 is non-empty; clears on a vc1 grant or when vc1 is empty at grant; saturates at VC0_BURST.
REQ-023 POP SHALL last exactly one cycle; pop_vcX SHALL be high only in POP, and the FSM SHALL go to WAIT.
REQ-024 WAIT SHALL last one cycle; on its exit edge the block SHALL capture data_vcX of the granted VC and go to PUSH.
REQ-025 Routing: the captured bit [DATA_SIZE-2] SHALL select the destination (0->d0, 1->d1), and the word SHALL be driven unmodified on data_dY.
REQ-026 push_dY SHALL be high for exactly the one PUSH cycle, words_fwd SHALL increment on entry to PUSH, and the FSM SHALL then return to IDLE.
REQ-027 Throughput SHALL be one word per 4 cycles; latency from the grant decision to push SHALL be 3 edges.
REQ-028 A pause that rises after the grant SHALL NOT abort the transfer in progress; pause SHALL be sampled in IDLE only.
REQ-029 Empty flags SHALL be sampled in IDLE only, and pop_vc0 and pop_vc1 SHALL never be high together.
REQ-030 At most one of push_d0 and push_d1 SHALL be high in any cycle.

Reset
REQ-031 With reset_L=0, regardless of clk: state=IDLE, all pop and push outputs=0, data_d0=data_d1=0, words_fwd=0, streak counter=0, idle=1.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no push; after release, operation SHALL restart from IDLE.

Verification
REQ-033 Single word: vc0 holds 6'b010101 and vc1 is empty -> pop_vc0 pulses once; 3 edges after the grant, push_d1=1 with data_d1=6'b010101; words_fwd=1.
REQ-034 Starvation: both VCs hold 8 words, VC0_BURST=3 -> grant order vc0,vc0,vc0,vc1,vc0,vc0,vc0,vc1,...
REQ-035 Pause: pause_d0=1 while both VCs are non-empty -> no pop while paused; first pop occurs 1 edge after pause_d0 falls.
REQ-036 Pause during transfer: pause_d1 rises while in POP -> the word is still pushed; the next grant is held until the pause falls.
REQ-037 Reset in WAIT: reset_L pulsed low -> no push_dY, outputs return to reset values immediately, and the following transfer completes normally.
REQ-038 Wrap: 256 words forwarded -> words_fwd=0, and the data_d0/data_d1 sequence matches push order with bit [DATA_SIZE-2] routing.

Source files
------------

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: drains two virtual-channel FIFOs into two destinations.
// One word moves per four-cycle transfer (IDLE -> POP -> WAIT -> PUSH).
// vc0 has priority, but vc1 is granted after VC0_BURST back-to-back vc0
// grants made while vc1 had data waiting. Bit [DATA_SIZE-2] of each word
// selects the destination. All outputs are registered.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | sample pauses and empty flags, pick a VC when allowed
// POP     | pop strobe high to the granted FIFO for one cycle
// WAIT    | FIFO read data settles; captured on the exit edge
// PUSH    | push strobe high to the routed destination for one cycle
module vc_pop_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int VC0_BURST = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 fifo_empty_vc0,
  input  logic                 fifo_empty_vc1,
  input  logic [DATA_SIZE-1:0] data_vc0,
  input  logic [DATA_SIZE-1:0] data_vc1,
  input  logic                 pause_d0,
  input  logic                 pause_d1,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1,
  output logic                 idle,
  output logic [7:0]           words_fwd
);

  // streak counter only needs to reach VC0_BURST
  localparam int SW = (VC0_BURST < 1) ? 1 : $clog2(VC0_BURST + 1);
  localparam logic [SW-1:0] BURST_MAX = SW'(VC0_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_PUSH = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_gnt_vc1;
  logic                 w_gnt_vc1_nxt;
  logic [SW-1:0]        r_streak;
  logic [SW-1:0]        w_streak_nxt;
  logic                 r_pop_vc0;
  logic                 w_pop_vc0_nxt;
  logic                 r_pop_vc1;
  logic                 w_pop_vc1_nxt;
  logic                 r_push_d0;
  logic                 w_push_d0_nxt;
  logic                 r_push_d1;
  logic                 w_push_d1_nxt;
  logic [DATA_SIZE-1:0] r_data_d0;
  logic [DATA_SIZE-1:0] w_data_d0_nxt;
  logic [DATA_SIZE-1:0] r_data_d1;
  logic [DATA_SIZE-1:0] w_data_d1_nxt;
  logic [7:0]           r_words_fwd;
  logic [7:0]           w_words_fwd_nxt;
  logic                 r_idle;
  logic                 w_idle_nxt;

  logic                 w_can_grant;
  logic                 w_pick_vc1;
  logic [DATA_SIZE-1:0] w_word;

  // a grant needs both destinations open and at least one FIFO with data
  assign w_can_grant = !pause_d0 && !pause_d1 && (!fifo_empty_vc0 || !fifo_empty_vc1);
  // vc1 wins when vc0 has nothing, or when vc0 has used up its burst
  assign w_pick_vc1  = !fifo_empty_vc1 && (fifo_empty_vc0 || (r_streak == BURST_MAX));
  // read data of whichever FIFO was popped for this transfer
  assign w_word      = r_gnt_vc1 ? data_vc1 : data_vc0;

  // next-state and next-output logic; every register holds unless changed
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_vc1_nxt   = r_gnt_vc1;
    w_streak_nxt    = r_streak;
    w_pop_vc0_nxt   = 1'b0;
    w_pop_vc1_nxt   = 1'b0;
    w_push_d0_nxt   = 1'b0;
    w_push_d1_nxt   = 1'b0;
    w_data_d0_nxt   = r_data_d0;
    w_data_d1_nxt   = r_data_d1;
    w_words_fwd_nxt = r_words_fwd;

    case (r_state)
      ST_IDLE: begin
        if (w_can_grant) begin
          w_state_nxt   = ST_POP;
          w_gnt_vc1_nxt = w_pick_vc1;
          w_pop_vc1_nxt = w_pick_vc1;
          w_pop_vc0_nxt = !w_pick_vc1;
          // streak only counts vc0 wins that actually made vc1 wait
          if (w_pick_vc1 || fifo_empty_vc1) begin
            w_streak_nxt = '0;
          end else if (r_streak != BURST_MAX) begin
            w_streak_nxt = r_streak + 1'b1;
          end
        end
      end
      ST_POP: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_state_nxt     = ST_PUSH;
        w_words_fwd_nxt = r_words_fwd + 8'd1;
        if (w_word[DATA_SIZE-2]) begin
          w_push_d1_nxt = 1'b1;
          w_data_d1_nxt = w_word;
        end else begin
          w_push_d0_nxt = 1'b1;
          w_data_d0_nxt = w_word;
        end
      end
      ST_PUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_idle_nxt = (w_state_nxt == ST_IDLE);
  end

  // state and output registers; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ST_IDLE;
      r_gnt_vc1   <= 1'b0;
      r_streak    <= '0;
      r_pop_vc0   <= 1'b0;
      r_pop_vc1   <= 1'b0;
      r_push_d0   <= 1'b0;
      r_push_d1   <= 1'b0;
      r_data_d0   <= '0;
      r_data_d1   <= '0;
      r_words_fwd <= 8'd0;
      r_idle      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_vc1   <= w_gnt_vc1_nxt;
      r_streak    <= w_streak_nxt;
      r_pop_vc0   <= w_pop_vc0_nxt;
      r_pop_vc1   <= w_pop_vc1_nxt;
      r_push_d0   <= w_push_d0_nxt;
      r_push_d1   <= w_push_d1_nxt;
      r_data_d0   <= w_data_d0_nxt;
      r_data_d1   <= w_data_d1_nxt;
      r_words_fwd <= w_words_fwd_nxt;
      r_idle      <= w_idle_nxt;
    end
  end

  assign pop_vc0   = r_pop_vc0;
  assign pop_vc1   = r_pop_vc1;
  assign push_d0   = r_push_d0;
  assign push_d1   = r_push_d1;
  assign data_d0   = r_data_d0;
  assign data_d1   = r_data_d1;
  assign idle      = r_idle;
  assign words_fwd = r_words_fwd;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter. The bench plays both FIFOs (queues) and keeps a
// transfer-level model: each grant is a record (edge, vc, word) from which
// pop/push timing, routing, data hold and the forwarded count follow.
module tb_vc_pop_arbiter;
  localparam int DS    = 6;
  localparam int BURST = 3;

  logic          clk = 1'b0;
  logic          reset_L = 1'b1;
  logic          fifo_empty_vc0 = 1'b1;
  logic          fifo_empty_vc1 = 1'b1;
  logic [DS-1:0] data_vc0 = '0;
  logic [DS-1:0] data_vc1 = '0;
  logic          pause_d0 = 1'b0;
  logic          pause_d1 = 1'b0;
  logic          pop_vc0, pop_vc1, push_d0, push_d1, idle;
  logic [DS-1:0] data_d0, data_d1;
  logic [7:0]    words_fwd;

  vc_pop_arbiter #(.DATA_SIZE(DS), .VC0_BURST(BURST)) dut (
    .clk(clk), .reset_L(reset_L),
    .fifo_empty_vc0(fifo_empty_vc0), .fifo_empty_vc1(fifo_empty_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .pause_d0(pause_d0), .pause_d1(pause_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_d0(data_d0), .data_d1(data_d1),
    .idle(idle), .words_fwd(words_fwd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DS-1:0] q0[$];
  logic [DS-1:0] q1[$];
  int gnt_log[$];
  int push_cnt;
  int fill_pct;

  // model state
  int cyc;          // edges since reset release
  int next_free;    // earliest edge a new grant may happen
  int g_edge;       // edge of the latest grant
  int g_vc;
  logic [DS-1:0] g_word;
  int streak;
  int m_total;
  logic [DS-1:0] m_d0, m_d1;
  int pend_vc;
  logic [DS-1:0] pend_word;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; next_free = 1; g_edge = -100; g_vc = 0; g_word = '0;
    streak = 0; m_total = 0; m_d0 = '0; m_d1 = '0; pend_vc = -1; pend_word = '0;
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_pop_vc0"}, 32'(pop_vc0), 0);
    chk({pfx, "_pop_vc1"}, 32'(pop_vc1), 0);
    chk({pfx, "_push_d0"}, 32'(push_d0), 0);
    chk({pfx, "_push_d1"}, 32'(push_d1), 0);
    chk({pfx, "_data_d0"}, 32'(data_d0), 0);
    chk({pfx, "_data_d1"}, 32'(data_d1), 0);
    chk({pfx, "_words_fwd"}, 32'(words_fwd), 0);
    chk({pfx, "_idle"}, 32'(idle), 1);
  endtask

  // One cycle, entered just after a falling edge: check this cycle's outputs,
  // act as the FIFOs, drive inputs, let the model decide the next edge.
  task automatic step(input logic p0, input logic p1);
    int vc;
    logic in_push;
    in_push = (cyc == g_edge + 2);
    if (in_push) begin
      m_total++;
      if (g_word[DS-2]) m_d1 = g_word; else m_d0 = g_word;
    end
    chk("pop_vc0", 32'(pop_vc0), 32'(cyc == g_edge && g_vc == 0));
    chk("pop_vc1", 32'(pop_vc1), 32'(cyc == g_edge && g_vc == 1));
    chk("push_d0", 32'(push_d0), 32'(in_push && !g_word[DS-2]));
    chk("push_d1", 32'(push_d1), 32'(in_push && g_word[DS-2]));
    chk("data_d0", 32'(data_d0), 32'(m_d0));
    chk("data_d1", 32'(data_d1), 32'(m_d1));
    chk("words_fwd", 32'(words_fwd), 32'(m_total % 256));
    chk("idle", 32'(idle), 32'(!(cyc >= g_edge && cyc <= g_edge + 2)));
    chk("pop_excl", 32'(pop_vc0 & pop_vc1), 0);
    chk("push_excl", 32'(push_d0 & push_d1), 0);
    if (push_d0 || push_d1) push_cnt++;

    // FIFO read data is valid only in the cycle after the pop edge
    data_vc0 = (pend_vc == 0) ? pend_word : DS'($urandom);
    data_vc1 = (pend_vc == 1) ? pend_word : DS'($urandom);
    pend_vc = -1;
    if (pop_vc0) begin
      gnt_log.push_back(0);
      if (q0.size() > 0) begin pend_word = q0.pop_front(); pend_vc = 0; end
    end else if (pop_vc1) begin
      gnt_log.push_back(1);
      if (q1.size() > 0) begin pend_word = q1.pop_front(); pend_vc = 1; end
    end

    if (fill_pct > 0 && $urandom_range(99) < fill_pct) begin
      if ($urandom_range(1) == 1) begin
        if (q1.size() < 8) q1.push_back(DS'($urandom));
      end else begin
        if (q0.size() < 8) q0.push_back(DS'($urandom));
      end
    end
    pause_d0 = p0;
    pause_d1 = p1;
    fifo_empty_vc0 = (q0.size() == 0);
    fifo_empty_vc1 = (q1.size() == 0);

    if (cyc + 1 >= next_free && !p0 && !p1 && (q0.size() > 0 || q1.size() > 0)) begin
      vc = (q1.size() > 0 && (q0.size() == 0 || streak == BURST)) ? 1 : 0;
      if (vc == 1 || q1.size() == 0) streak = 0;
      else if (streak < BURST) streak++;
      g_edge = cyc + 1;
      g_vc = vc;
      g_word = (vc == 1) ? q1[0] : q0[0];
      next_free = cyc + 5;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int exp_order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    model_reset();
    fill_pct = 0;
    push_cnt = 0;

    // reset applied with no clock edge yet
    #1 reset_L = 1'b0;
    #2;
    chk_reset_values("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();

    // single word 010101 on vc0 -> destination 1
    q0.push_back(6'b010101);
    gnt_log.delete();
    repeat (8) step(1'b0, 1'b0);
    chk("single_words", 32'(words_fwd), 1);
    chk("single_grants", 32'(gnt_log.size()), 1);
    chk("single_data_d1", 32'(data_d1), 32'(6'b010101));

    // starvation: 8 words each
    for (int i = 0; i < 8; i++) begin
      q0.push_back(DS'($urandom));
      q1.push_back(DS'($urandom));
    end
    gnt_log.delete();
    repeat (70) step(1'b0, 1'b0);
    chk("starve_grants", 32'(gnt_log.size()), 16);
    for (int i = 0; i < 8; i++) begin
      if (i < gnt_log.size()) chk($sformatf("starve_order%0d", i), 32'(gnt_log[i]), 32'(exp_order[i]));
      else chk($sformatf("starve_order%0d", i), 32'hdead, 32'(exp_order[i]));
    end

    // pause_d0 held while both VCs have data
    for (int i = 0; i < 3; i++) begin
      q0.push_back(DS'($urandom));
      q1.push_back(DS'($urandom));
    end
    gnt_log.delete();
    repeat (12) step(1'b1, 1'b0);
    chk("pause_no_pop", 32'(gnt_log.size()), 0);
    step(1'b0, 1'b0);
    chk("pause_first_pop", 32'(pop_vc0 | pop_vc1), 1);
    repeat (30) step(1'b0, 1'b0);

    // pause_d1 rises while in POP
    q0.push_back(DS'($urandom));
    q0.push_back(DS'($urandom));
    n = 0;
    while (cyc != g_edge && n < 10) begin step(1'b0, 1'b0); n++; end
    chk("pop_wait_timeout", 32'(cyc == g_edge), 1);
    push_cnt = 0;
    gnt_log.delete();
    repeat (12) step(1'b0, 1'b1);
    chk("pausexfer_push", 32'(push_cnt), 1);
    chk("pausexfer_held", 32'(gnt_log.size()), 1);
    step(1'b0, 1'b0);
    chk("pausexfer_resume", 32'(pop_vc0), 1);
    repeat (10) step(1'b0, 1'b0);

    // reset pulsed during WAIT
    q1.push_back(DS'($urandom));
    q1.push_back(DS'($urandom));
    n = 0;
    while (cyc != g_edge + 1 && n < 12) begin step(1'b0, 1'b0); n++; end
    chk("wait_state_timeout", 32'(cyc == g_edge + 1), 1);
    #2 reset_L = 1'b0;
    #1;
    chk_reset_values("midrst");
    push_cnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1 if (push_d0 || push_d1) push_cnt++;
    end
    chk("midrst_no_push", 32'(push_cnt), 0);
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
    repeat (12) step(1'b0, 1'b0);
    chk("midrst_after", 32'(words_fwd), 1);

    // random traffic and pauses until 256 words have gone through
    fill_pct = 50;
    push_cnt = 0;
    n = 0;
    while (m_total < 256 && n < 4000) begin
      step($urandom_range(9) == 0, $urandom_range(9) == 0);
      n++;
    end
    chk("wrap_total", 32'(m_total), 256);
    chk("wrap_words_fwd", 32'(words_fwd), 0);
    fill_pct = 0;
    repeat (80) step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
